imem_loader: RTL and testbench

//   Boot-time program loader upstream of inst_memory. Takes a byte stream (valid/ready) from a host link.

---
 rtl/imem_loader_pkg.sv | 25 ++
 rtl/imem_loader_if.sv | 38 +++
 rtl/imem_loader_word_packer.sv | 45 ++++
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the boot-time instruction loader
// Purpose : loader FSM state encoding, byte/word/length widths and a small state helper.
// Ports   : none (package loader_pkg).
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CSUM,
      DONE,
      ERROR
   } loader_state_t;

   localparam int BYTE_W         = 8;
   localparam int BYTES_PER_WORD = 4;
   localparam int LEN_W          = 16;

   // States in which the loader is inside a frame and takes stream bytes.
   function automatic logic is_frame_state(input loader_state_t s);
      return (s == LEN_LO) || (s == LEN_HI) || (s == DATA) || (s == CSUM);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream and inst_memory write port bundle for the loader
// Purpose : groups the host byte stream (valid/ready) and the inst_memory write port.
// Ports   : byte_i, byte_valid_i, byte_ready_o    host byte stream
//           imem_we_o, imem_addr_o, imem_wdata_o  inst_memory write port
//           modport slave  : loader side
//           modport master : host / memory side
interface imem_loader_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
);
   import loader_pkg::*;

   logic [BYTE_W-1:0]        byte_i;
   logic                     byte_valid_i;
   logic                     byte_ready_o;
   logic                     imem_we_o;
   logic [ADDRESS_WIDTH-1:0] imem_addr_o;
   logic [DATA_WIDTH-1:0]    imem_wdata_o;

   modport slave (
      input  byte_i,
      input  byte_valid_i,
      output byte_ready_o,
      output imem_we_o,
      output imem_addr_o,
      output imem_wdata_o
   );

   modport master (
      output byte_i,
      output byte_valid_i,
      input  byte_ready_o,
      input  imem_we_o,
      input  imem_addr_o,
      input  imem_wdata_o
   );

endinterface

// File: rtl/imem_loader_word_packer.sv
// rtl/imem_loader_word_packer.sv - packs accepted stream bytes into little-endian words
// Purpose : 2-bit byte counter plus byte-insert register; flags the byte that completes a word.
// Ports   : clk, rst       clock, synchronous active-high reset
//           clear_i        restart packing (honoured start of a new frame)
//           byte_en_i      a data byte is accepted this cycle
//           byte_i         the data byte
//           word_o         assembled word including the current byte in the top lane
//           word_valid_o   combinational: this accepted byte completes word_o
module word_packer
   import loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear_i,
   input  logic                  byte_en_i,
   input  logic [BYTE_W-1:0]     byte_i,
   output logic [DATA_WIDTH-1:0] word_o,
   output logic                  word_valid_o
);

   logic [1:0]            cnt_q;
   logic [DATA_WIDTH-1:0] data_q;

   // The completing byte is merged combinationally so the top can register
   // the finished word on the same edge that accepts byte 3.
   always_comb begin
      word_o = data_q;
      word_o[DATA_WIDTH-1 -: BYTE_W] = byte_i;
   end

   assign word_valid_o = byte_en_i && (cnt_q == 2'd3);

   always_ff @(posedge clk) begin
      if (rst || clear_i) begin
         cnt_q  <= 2'd0;
         data_q <= '0;
      end else if (byte_en_i) begin
         data_q[{cnt_q, 3'b000} +: BYTE_W] <= byte_i;
         cnt_q <= cnt_q + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time program loader writing a checksummed image into inst_memory
// Purpose : parses LEN_LO, LEN_HI, 4*N data bytes, XOR checksum; writes words; holds core in reset.
// Ports   : clk, rst         clock, synchronous active-high reset
//           start_i          begin (re)load; honoured in IDLE, DONE, ERROR
//           bus              byte stream in, inst_memory write port out (slave modport)
//           core_rst_o       core reset, low only in DONE
//           done_o, error_o  image loaded OK / length or checksum error
//           words_loaded_o   words written in the current frame
module imem_loader
   import loader_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int MEM_SIZE      = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start_i,
   imem_loader_if.slave             bus,
   output logic                     core_rst_o,
   output logic                     done_o,
   output logic                     error_o,
   output logic [ADDRESS_WIDTH-1:0] words_loaded_o
);

   loader_state_t         state_q, state_d;
   logic [LEN_W-1:0]      len_q;
   logic [LEN_W-1:0]      len_full;
   logic [BYTE_W-1:0]     csum_q;
   logic                  accept;
   logic                  start_ok;
   logic                  data_en;
   logic                  word_valid;
   logic                  last_word;
   logic [DATA_WIDTH-1:0] word;

   assign accept   = bus.byte_valid_i && bus.byte_ready_o;
   assign start_ok = start_i && !is_frame_state(state_q);
   assign data_en  = accept && (state_q == DATA);
   // Full length as seen while the LEN_HI byte is on the bus.
   assign len_full = {bus.byte_i, len_q[BYTE_W-1:0]};
   // words_loaded_o still holds the index of the word being completed.
   assign last_word = (words_loaded_o + ADDRESS_WIDTH'(1)) == ADDRESS_WIDTH'(len_q);

   word_packer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_packer (
      .clk          (clk),
      .rst          (rst),
      .clear_i      (start_ok),
      .byte_en_i    (data_en),
      .byte_i       (bus.byte_i),
      .word_o       (word),
      .word_valid_o (word_valid)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE, ERROR: begin
            if (start_i) state_d = LEN_LO;
         end
         LEN_LO: begin
            if (accept) state_d = LEN_HI;
         end
         LEN_HI: begin
            if (accept) begin
               if (int'(len_full) > MEM_SIZE) state_d = ERROR;
               else if (len_full == '0)       state_d = CSUM;
               else                           state_d = DATA;
            end
         end
         DATA: begin
            if (word_valid && last_word) state_d = CSUM;
         end
         CSUM: begin
            if (accept) state_d = (bus.byte_i == csum_q) ? DONE : ERROR;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= IDLE;
         len_q            <= '0;
         csum_q           <= '0;
         words_loaded_o   <= '0;
         bus.byte_ready_o <= 1'b0;
         bus.imem_we_o    <= 1'b0;
         bus.imem_addr_o  <= '0;
         bus.imem_wdata_o <= '0;
         core_rst_o       <= 1'b1;
         done_o           <= 1'b0;
         error_o          <= 1'b0;
      end else begin
         state_q <= state_d;
         // Outputs are registered from the next state so they line up with state_q.
         bus.byte_ready_o <= is_frame_state(state_d);
         core_rst_o       <= (state_d != DONE);
         done_o           <= (state_d == DONE);
         error_o          <= (state_d == ERROR);
         bus.imem_we_o    <= 1'b0;

         if (start_ok) begin
            len_q          <= '0;
            csum_q         <= '0;
            words_loaded_o <= '0;
         end else if (accept) begin
            if (state_q != CSUM)   csum_q <= csum_q ^ bus.byte_i;
            if (state_q == LEN_LO) len_q[BYTE_W-1:0] <= bus.byte_i;
            if (state_q == LEN_HI) len_q <= len_full;
         end

         if (word_valid) begin
            bus.imem_we_o    <= 1'b1;
            bus.imem_addr_o  <= words_loaded_o << 2;
            bus.imem_wdata_o <= word;
            words_loaded_o   <= words_loaded_o + ADDRESS_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader with a write scoreboard
module tb_imem_loader;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        core_rst_o;
   logic        done_o;
   logic        error_o;
   logic [31:0] words_loaded_o;

   int vectors     = 0;
   int miscompares = 0;
   int nwrites     = 0;

   logic [63:0] exp_q[$];

   imem_loader_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) bus ();

   imem_loader #(
      .DATA_WIDTH    (32),
      .ADDRESS_WIDTH (32),
      .MEM_SIZE      (256)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start_i),
      .bus            (bus),
      .core_rst_o     (core_rst_o),
      .done_o         (done_o),
      .error_o        (error_o),
      .words_loaded_o (words_loaded_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every write pulse must match the oldest expected {addr, data}.
   always @(negedge clk) begin
      if (bus.imem_we_o) begin
         logic [63:0] e;
         nwrites++;
         chk("write_expected", (exp_q.size() > 0), 1'b1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("imem_addr", bus.imem_addr_o, e[63:32]);
            chk("imem_wdata", bus.imem_wdata_o, e[31:0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rnd);
      int guard;
      if (rnd) begin
         while ($urandom_range(0, 1) == 0) begin
            bus.byte_valid_i = 1'b0;
            tick();
         end
      end
      bus.byte_i       = b;
      bus.byte_valid_i = 1'b1;
      guard = 0;
      while (!bus.byte_ready_o && guard < 20) begin
         tick();
         guard++;
      end
      if (guard >= 20) chk("byte_ready_timeout", bus.byte_ready_o, 1'b1);
      tick();
      bus.byte_valid_i = 1'b0;
   endtask

   function automatic logic [7:0] frame_csum(input int n, input logic [31:0] w[$]);
      logic [7:0] c;
      c = n[7:0] ^ n[15:8];
      foreach (w[i]) c ^= w[i][7:0] ^ w[i][15:8] ^ w[i][23:16] ^ w[i][31:24];
      return c;
   endfunction

   // Sends a whole frame (no start pulse); bad_csum flips the checksum byte.
   task automatic send_frame(input int n, input logic [31:0] w[$], input bit bad_csum, input bit rnd);
      logic [31:0] word;
      send_byte(n[7:0], rnd);
      send_byte(n[15:8], rnd);
      for (int i = 0; i < n; i++) begin
         word = w[i];
         exp_q.push_back({32'(i * 4), word});
         for (int k = 0; k < 4; k++) send_byte(word[8*k +: 8], rnd);
      end
      send_byte(frame_csum(n, w) ^ {7'd0, bad_csum}, rnd);
   endtask

   task automatic check_status(input string tag, input logic d, input logic e, input logic cr,
                               input logic [31:0] wl);
      chk({tag, "_done"},     done_o,         d);
      chk({tag, "_error"},    error_o,        e);
      chk({tag, "_core_rst"}, core_rst_o,     cr);
      chk({tag, "_words"},    words_loaded_o, wl);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ready"}, bus.byte_ready_o, 1'b0);
      chk({tag, "_we"},    bus.imem_we_o,    1'b0);
      chk({tag, "_addr"},  bus.imem_addr_o,  32'd0);
      chk({tag, "_wdata"}, bus.imem_wdata_o, 32'd0);
      check_status(tag, 1'b0, 1'b0, 1'b1, 32'd0);
   endtask

   initial begin
      logic [31:0] prog[$];
      logic [31:0] none[$];
      logic [31:0] prog2[$];
      int w0;

      prog  = '{32'h00500013, 32'h00100093};
      none  = '{};
      prog2 = '{32'h00000073};

      rst = 1'b1;
      start_i = 1'b0;
      bus.byte_i = 8'h00;
      bus.byte_valid_i = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // 1: two-word image, good checksum
      pulse_start();
      chk("t1_ready_after_start", bus.byte_ready_o, 1'b1);
      w0 = nwrites;
      send_frame(2, prog, 1'b0, 1'b0);
      check_status("t1", 1'b1, 1'b0, 1'b0, 32'd2);
      chk("t1_ready_done", bus.byte_ready_o, 1'b0);
      chk("t1_nwrites", nwrites - w0, 2);
      chk("t1_queue_empty", exp_q.size(), 0);

      // 2: same image, bad checksum; words still written
      pulse_start();
      chk("t2_core_rst_restart", core_rst_o, 1'b1);
      w0 = nwrites;
      send_frame(2, prog, 1'b1, 1'b0);
      check_status("t2", 1'b0, 1'b1, 1'b1, 32'd2);
      chk("t2_nwrites", nwrites - w0, 2);
      chk("t2_queue_empty", exp_q.size(), 0);

      // 3: N=257 exceeds MEM_SIZE
      pulse_start();
      w0 = nwrites;
      send_byte(8'h01, 1'b0);
      send_byte(8'h01, 1'b0);
      check_status("t3", 1'b0, 1'b1, 1'b1, 32'd0);
      chk("t3_ready", bus.byte_ready_o, 1'b0);
      repeat (3) tick();
      chk("t3_nwrites", nwrites - w0, 0);
      chk("t3_still_error", error_o, 1'b1);

      // 4a: empty image
      pulse_start();
      w0 = nwrites;
      send_frame(0, none, 1'b0, 1'b0);
      check_status("t4a", 1'b1, 1'b0, 1'b0, 32'd0);
      chk("t4a_nwrites", nwrites - w0, 0);

      // 4b: test 1 image with random valid gaps
      pulse_start();
      w0 = nwrites;
      send_frame(2, prog, 1'b0, 1'b1);
      check_status("t4b", 1'b1, 1'b0, 1'b0, 32'd2);
      chk("t4b_nwrites", nwrites - w0, 2);
      chk("t4b_queue_empty", exp_q.size(), 0);

      // 5: reset after 6 data bytes of an N=2 frame
      pulse_start();
      w0 = nwrites;
      send_byte(8'h02, 1'b0);
      send_byte(8'h00, 1'b0);
      exp_q.push_back({32'd0, prog[0]});
      for (int k = 0; k < 4; k++) send_byte(prog[0][8*k +: 8], 1'b0);
      send_byte(prog[1][7:0], 1'b0);
      send_byte(prog[1][15:8], 1'b0);
      rst = 1'b1;
      tick();
      check_reset_outputs("t5");
      rst = 1'b0;
      repeat (3) tick();
      chk("t5_nwrites", nwrites - w0, 1);
      chk("t5_queue_empty", exp_q.size(), 0);
      chk("t5_idle_ready", bus.byte_ready_o, 1'b0);

      // 6: reload from DONE
      pulse_start();
      send_frame(0, none, 1'b0, 1'b0);
      chk("t6_pre_done", done_o, 1'b1);
      pulse_start();
      chk("t6_core_rst_after_start", core_rst_o, 1'b1);
      chk("t6_done_cleared", done_o, 1'b0);
      w0 = nwrites;
      send_frame(1, prog2, 1'b0, 1'b0);
      check_status("t6", 1'b1, 1'b0, 1'b0, 32'd1);
      chk("t6_nwrites", nwrites - w0, 1);
      chk("t6_queue_empty", exp_q.size(), 0);

      // start_i mid-frame is ignored
      pulse_start();
      send_byte(8'h01, 1'b0);
      pulse_start();
      chk("midframe_start_ready", bus.byte_ready_o, 1'b1);
      send_byte(8'h00, 1'b0);
      exp_q.push_back({32'd0, 32'hdeadbeef});
      for (int k = 0; k < 4; k++) begin
         logic [31:0] dw;
         dw = 32'hdeadbeef;
         send_byte(dw[8*k +: 8], 1'b0);
      end
      tick();
      chk("midframe_words", words_loaded_o, 32'd1);
      chk("midframe_queue_empty", exp_q.size(), 0);

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
